sc_road_scroller: RTL and testbench
===================================

Name: sc_road_scroller

Overview:
- Parametrised game-field engine for the LED-matrix road game. Holds a ROWS x COLS playfield that scrolls toward the player row at a programmable rate, with LFSR-generated obstacles.
- Tracks a one-hot player car in the bottom row, moved by left/right buttons, and detects collisions.
- Keeps a saturating score.
- Exposes a row-read port that feeds the matrix column mux / max7219 driver directly.

Parameters:
- ROWS, 8, playfield rows; row 0 is the top, row ROWS-1 is the player row.
- COLS, 8, lanes per row (bits per row).
- TICK_DIV, 25000000, clocks per scroll step; must be >= 2.
- TICK_MIN, 5000000, minimum scroll period (used only with the speed-up feature).
- GAP_ROWS, 3, an obstacle row is inserted every GAP_ROWS scrolls; 0 disables obstacles.
- SCORE_W, 8, score width.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- SC_ROADSCROLLER_CLOCK_50  in  1  system clock.
- SC_ROADSCROLLER_RESET_InLow  in  1  asynchronous active-low reset.
- SC_ROADSCROLLER_startButton_InLow  in  1  debounced level, low = pressed.
- SC_ROADSCROLLER_leftButton_InLow  in  1  debounced level, low = pressed.
- SC_ROADSCROLLER_rightButton_InLow  in  1  debounced level, low = pressed.
- SC_ROADSCROLLER_rowaddr_In  in  $clog2(ROWS)  row select for display.
- SC_ROADSCROLLER_rowdata_OutBUS  out  COLS  selected row, with the car overlaid on row ROWS-1.
- SC_ROADSCROLLER_score_OutBUS  out  SCORE_W  current score.
- SC_ROADSCROLLER_state_Out  out  2  00 IDLE, 01 RUN, 10 OVER.
- SC_ROADSCROLLER_gameover_OutLow  out  1  low while in OVER.
- SC_ROADSCROLLER_scroll_Out  out  1  one-cycle pulse on each scroll step.

Behaviour:

Reset (asynchronous, RESET_InLow=0):
- state IDLE, field all 0, car = 1<<(COLS/2), score 0, LFSR = SEED.
- tick counter 0, gap counter 0, period = TICK_DIV.
- Outputs: scroll_Out 0, gameover_OutLow 1.
- Button edge registers are preset to 1 (released), so a button held through reset release does not fire.

Buttons:
- A press is the registered 1->0 edge of the button input.
- The press acts in the cycle after the edge is detected (1-cycle latency).

FSM:
- IDLE, start press -> RUN. On entry: field cleared, car centred, score 0, tick counter 0, gap counter 0. The LFSR is not reseeded.
- RUN, collision -> OVER.
  - Collision = (field[ROWS-1] & car) != 0, evaluated on registered state every cycle.
- OVER, start press -> IDLE. Field, car and score are held until the start press.
- Start presses in RUN are ignored.

Scroll (RUN only):
- Tick counter counts 0..period-1. At period-1 it wraps to 0 and a scroll step occurs; scroll_Out pulses in that same cycle.
- Scroll step:
  - field[i] <= field[i-1] for i >= 1.
  - field[0] <= new row.
  - LFSR advances one step (Galois, x^16+x^14+x^13+x^11+1).
  - Score increments, saturating at 2^SCORE_W-1.
- New row:
  - If GAP_ROWS != 0 and the gap counter == GAP_ROWS-1: new row = 1 << (lfsr[7:0] % COLS), using the pre-advance LFSR value, and the gap counter wraps to 0.
  - Otherwise the new row is 0 and the gap counter increments.
- In IDLE and OVER the tick counter is held at 0; the field and LFSR are frozen.

Car movement (RUN only):
- Left press: car <<= 1, saturating at bit COLS-1.
- Right press: car >>= 1, saturating at bit 0.
- Left and right pressed in the same cycle: no move.

Simultaneous events:
- A move and a scroll in the same cycle both apply.
- Collision is evaluated on the resulting state in the next cycle.
- A scroll that occurs in the cycle a collision is detected still increments the score.

Row-read port (combinational):
- rowdata = field[addr], OR'd with car when addr == ROWS-1.
- Out-of-range addr returns 0.

Reset mid-RUN:
- Immediate return to the reset values, without waiting for a clock edge.

Optional Feature:
Macro: SC_ROADSCROLLER_SPEEDUP_EN
- Defined:
  - Every 16 score increments, period <= max(TICK_MIN, period - (period>>3)).
  - The period update takes effect at the next tick-counter wrap.
  - Period is restored to TICK_DIV on the IDLE->RUN transition.
- Undefined: period is constant at TICK_DIV; TICK_MIN is unused.

Decomposition:
- Package sc_road_pkg holds:
  - state encoding constants (IDLE/RUN/OVER),
  - LFSR width and tap mask,
  - speed-up step constants (16 score increments, shift of 3).
- Sub-module sc_lfsr16: parametrised by SEED, with an advance enable and a 16-bit output; reusable by the background generator.

Test Plan:
1. Reset applied then released, with ROWS=8 and COLS=8 -> state 00, score 0, gameover_OutLow 1, row 7 reads 8'b00010000, rows 0-6 read 0.
2. TICK_DIV=4, GAP_ROWS=0, start press -> state 01 two cycles after the edge; scroll_Out pulses every 4 clocks; score=10 after 40 clocks of RUN.
3. Five right presses from the centred car -> car sequence 0x10, 0x08, 0x04, 0x02, 0x01, 0x01; left and right pressed in the same cycle -> car unchanged.
4. TICK_DIV=4, GAP_ROWS=3, SEED=16'hACE1, bench LFSR reference model, car parked in the first obstacle's lane -> OVER exactly 1 cycle after the obstacle reaches row 7; gameover_OutLow 0; score frozen; start press -> IDLE.
5. SCORE_W=4, GAP_ROWS=0, run 20 scroll steps -> score saturates at 15 with no wrap to 0.
6. Reset asserted mid-RUN, between clock edges -> outputs take reset values before the next clock edge. With SC_ROADSCROLLER_SPEEDUP_EN defined, TICK_DIV=64 and TICK_MIN=40, scroll interval goes 64 -> 56 after 16 scroll steps, stays >= 40, and is 64 again after restart.

Source files
------------

// File: rtl/sc_road_pkg.sv
// sc_road_pkg: shared state encoding, LFSR polynomial and speed-up constants
// for the LED-matrix road game engine.
package sc_road_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } roadState_t;

    localparam int LFSR_W = 16;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int SPEEDUP_STEPS = 16;
    localparam int SPEEDUP_SHIFT = 3;

    function automatic logic [LFSR_W-1:0] lfsrStep(
        input logic [LFSR_W-1:0] cur
    );
        logic [LFSR_W-1:0] nxt;
        nxt = cur >> 1;
        if (cur[0]) nxt = nxt ^ LFSR_TAPS;
        return nxt;
    endfunction

endpackage

// File: rtl/sc_lfsr16.sv
// sc_lfsr16: 16-bit Galois LFSR with a step enable.
// Reloads SEED on reset; SEED must be non-zero.
module sc_lfsr16
    import sc_road_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              advance,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsrStep(value);
        end
    end

endmodule

// File: rtl/sc_road_scroller.sv
// sc_road_scroller: scrolling playfield, player car, collision and score.
// Define SC_ROADSCROLLER_SPEEDUP_EN to shorten the scroll period as score grows.
module sc_road_scroller
    import sc_road_pkg::*;
#(
    parameter int          ROWS     = 8,
    parameter int          COLS     = 8,
    parameter int          TICK_DIV = 25000000,
    parameter int          TICK_MIN = 5000000,
    parameter int          GAP_ROWS = 3,
    parameter int          SCORE_W  = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                    SC_ROADSCROLLER_CLOCK_50,
    input  logic                    SC_ROADSCROLLER_RESET_InLow,
    input  logic                    SC_ROADSCROLLER_startButton_InLow,
    input  logic                    SC_ROADSCROLLER_leftButton_InLow,
    input  logic                    SC_ROADSCROLLER_rightButton_InLow,
    input  logic [$clog2(ROWS)-1:0] SC_ROADSCROLLER_rowaddr_In,
    output logic [COLS-1:0]         SC_ROADSCROLLER_rowdata_OutBUS,
    output logic [SCORE_W-1:0]      SC_ROADSCROLLER_score_OutBUS,
    output logic [1:0]              SC_ROADSCROLLER_state_Out,
    output logic                    SC_ROADSCROLLER_gameover_OutLow,
    output logic                    SC_ROADSCROLLER_scroll_Out
);

    localparam int ROW_W   = $clog2(ROWS);
    localparam int LANE_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int GAP_W   = (GAP_ROWS > 1) ? $clog2(GAP_ROWS) : 1;
    // Counter sized for whichever period bound is larger
    localparam int CNT_MAX = (TICK_DIV > TICK_MIN) ? TICK_DIV : TICK_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [COLS-1:0] CAR_HOME = COLS'(1) << (COLS / 2);

    logic clk;
    logic rstN;
    logic [ROW_W-1:0] rowAddr;

    assign clk     = SC_ROADSCROLLER_CLOCK_50;
    assign rstN    = SC_ROADSCROLLER_RESET_InLow;
    assign rowAddr = SC_ROADSCROLLER_rowaddr_In;

    roadState_t state;
    logic [COLS-1:0] field [ROWS];
    logic [COLS-1:0] car;
    logic [SCORE_W-1:0] score;
    logic [CNT_W-1:0] tickCnt;
    logic [CNT_W-1:0] period;
    logic [GAP_W-1:0] gapCnt;
    logic [LFSR_W-1:0] lfsr;

    logic startQ;
    logic leftQ;
    logic rightQ;
    logic startPress;
    logic leftPress;
    logic rightPress;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            startQ     <= 1'b1;
            leftQ      <= 1'b1;
            rightQ     <= 1'b1;
            startPress <= 1'b0;
            leftPress  <= 1'b0;
            rightPress <= 1'b0;
        end else begin
            startQ     <= SC_ROADSCROLLER_startButton_InLow;
            leftQ      <= SC_ROADSCROLLER_leftButton_InLow;
            rightQ     <= SC_ROADSCROLLER_rightButton_InLow;
            startPress <= startQ & ~SC_ROADSCROLLER_startButton_InLow;
            leftPress  <= leftQ & ~SC_ROADSCROLLER_leftButton_InLow;
            rightPress <= rightQ & ~SC_ROADSCROLLER_rightButton_InLow;
        end
    end

    logic running;
    logic startRun;
    logic tickWrap;
    logic scroll;
    logic collide;
    logic gapHit;
    logic [LANE_W-1:0] laneSel;
    logic [COLS-1:0] newRow;
    logic [COLS-1:0] carNext;
    logic unusedLfsrHi;

    assign running  = (state == ST_RUN);
    assign startRun = (state == ST_IDLE) && startPress;
    assign tickWrap = (tickCnt == period - 1'b1);
    assign scroll   = running && tickWrap;
    assign collide  = running && |(field[ROWS-1] & car);
    assign gapHit   = (GAP_ROWS != 0) &&
                      (gapCnt == GAP_W'(GAP_ROWS - 1));
    assign laneSel  = LANE_W'(int'(lfsr[7:0]) % COLS);
    assign unusedLfsrHi = ^lfsr[LFSR_W-1:8];

    always_comb begin
        newRow = '0;
        if (gapHit) newRow[laneSel] = 1'b1;
    end

    // Opposing presses in one cycle cancel; edges saturate
    always_comb begin
        carNext = car;
        unique case (1'b1)
            leftPress && !rightPress: begin
                if (!car[COLS-1]) carNext = car << 1;
            end
            rightPress && !leftPress: begin
                if (!car[0]) carNext = car >> 1;
            end
            default: carNext = car;
        endcase
    end

    sc_lfsr16 #(
        .SEED(SEED)
    ) uLfsr (
        .clk(clk),
        .rstN(rstN),
        .advance(scroll),
        .value(lfsr)
    );

`ifdef SC_ROADSCROLLER_SPEEDUP_EN
    localparam int SPEED_W = $clog2(SPEEDUP_STEPS);

    logic [SPEED_W-1:0] speedCnt;
    logic [CNT_W-1:0] periodCut;
    logic [CNT_W-1:0] periodNext;

    assign periodCut  = period - (period >> SPEEDUP_SHIFT);
    assign periodNext = (periodCut < CNT_W'(TICK_MIN)) ?
                        CNT_W'(TICK_MIN) : periodCut;

    // Updated on a scroll, which is itself a tick wrap
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            period   <= CNT_W'(TICK_DIV);
            speedCnt <= '0;
        end else if (startRun) begin
            period   <= CNT_W'(TICK_DIV);
            speedCnt <= '0;
        end else if (scroll) begin
            speedCnt <= speedCnt + 1'b1;
            if (speedCnt == SPEED_W'(SPEEDUP_STEPS - 1)) begin
                period <= periodNext;
            end
        end
    end
`else
    assign period = CNT_W'(TICK_DIV);
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= ST_IDLE;
            car     <= CAR_HOME;
            score   <= '0;
            tickCnt <= '0;
            gapCnt  <= '0;
            for (int i = 0; i < ROWS; i++) field[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (startPress) begin
                        state   <= ST_RUN;
                        car     <= CAR_HOME;
                        score   <= '0;
                        tickCnt <= '0;
                        gapCnt  <= '0;
                        for (int i = 0; i < ROWS; i++) field[i] <= '0;
                    end
                end
                ST_RUN: begin
                    car     <= carNext;
                    tickCnt <= tickWrap ? '0 : tickCnt + 1'b1;
                    if (scroll) begin
                        for (int i = ROWS - 1; i > 0; i--) begin
                            field[i] <= field[i-1];
                        end
                        field[0] <= newRow;
                        gapCnt   <= gapHit ? '0 : gapCnt + 1'b1;
                        if (score != '1) score <= score + 1'b1;
                    end
                    if (collide) begin
                        state   <= ST_OVER;
                        tickCnt <= '0;
                    end
                end
                ST_OVER: begin
                    if (startPress) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        SC_ROADSCROLLER_rowdata_OutBUS = '0;
        if (int'(rowAddr) < ROWS) begin
            SC_ROADSCROLLER_rowdata_OutBUS = field[rowAddr];
        end
        if (rowAddr == ROW_W'(ROWS - 1)) begin
            SC_ROADSCROLLER_rowdata_OutBUS =
                SC_ROADSCROLLER_rowdata_OutBUS | car;
        end
    end

    assign SC_ROADSCROLLER_score_OutBUS    = score;
    assign SC_ROADSCROLLER_state_Out       = state;
    assign SC_ROADSCROLLER_gameover_OutLow = (state != ST_OVER);
    assign SC_ROADSCROLLER_scroll_Out      = scroll;

endmodule

// File: tb/tb_sc_road_scroller.sv
// tb_sc_road_scroller: directed checks of reset, scroll, car, collision,
// score saturation, async reset and (when enabled) the speed-up feature.
module tb_sc_road_scroller;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsrRef(input logic [15:0] v);
        logic fb;
        fb = v[0];
        v  = {1'b0, v[15:1]};
        if (fb) v = v ^ 16'b1011_0100_0000_0000;
        return v;
    endfunction

    function automatic int laneAfter(input int steps);
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < steps; i++) v = lfsrRef(v);
        return int'(v[7:0]) % 8;
    endfunction

    logic stA = 1'b1, lfA = 1'b1, rtA = 1'b1;
    logic [2:0] addrA = 3'd7;
    logic [7:0] rowA;
    logic [3:0] scoreA;
    logic [1:0] stateA;
    logic goA, scrA;

    sc_road_scroller #(
        .ROWS(8), .COLS(8), .TICK_DIV(4), .TICK_MIN(2),
        .GAP_ROWS(0), .SCORE_W(4), .SEED(16'hACE1)
    ) dutA (
        .SC_ROADSCROLLER_CLOCK_50(clk),
        .SC_ROADSCROLLER_RESET_InLow(rstN),
        .SC_ROADSCROLLER_startButton_InLow(stA),
        .SC_ROADSCROLLER_leftButton_InLow(lfA),
        .SC_ROADSCROLLER_rightButton_InLow(rtA),
        .SC_ROADSCROLLER_rowaddr_In(addrA),
        .SC_ROADSCROLLER_rowdata_OutBUS(rowA),
        .SC_ROADSCROLLER_score_OutBUS(scoreA),
        .SC_ROADSCROLLER_state_Out(stateA),
        .SC_ROADSCROLLER_gameover_OutLow(goA),
        .SC_ROADSCROLLER_scroll_Out(scrA)
    );

    logic stB = 1'b1, lfB = 1'b1, rtB = 1'b1;
    logic [2:0] addrB = 3'd7;
    logic [7:0] rowB;
    logic [7:0] scoreB;
    logic [1:0] stateB;
    logic goB, scrB;

    sc_road_scroller #(
        .ROWS(8), .COLS(8), .TICK_DIV(4), .TICK_MIN(2),
        .GAP_ROWS(3), .SCORE_W(8), .SEED(16'hACE1)
    ) dutB (
        .SC_ROADSCROLLER_CLOCK_50(clk),
        .SC_ROADSCROLLER_RESET_InLow(rstN),
        .SC_ROADSCROLLER_startButton_InLow(stB),
        .SC_ROADSCROLLER_leftButton_InLow(lfB),
        .SC_ROADSCROLLER_rightButton_InLow(rtB),
        .SC_ROADSCROLLER_rowaddr_In(addrB),
        .SC_ROADSCROLLER_rowdata_OutBUS(rowB),
        .SC_ROADSCROLLER_score_OutBUS(scoreB),
        .SC_ROADSCROLLER_state_Out(stateB),
        .SC_ROADSCROLLER_gameover_OutLow(goB),
        .SC_ROADSCROLLER_scroll_Out(scrB)
    );

`ifdef SC_ROADSCROLLER_SPEEDUP_EN
    logic stS = 1'b1, lfS = 1'b1, rtS = 1'b1;
    logic [2:0] addrS = 3'd7;
    logic [7:0] rowS;
    logic [7:0] scoreS;
    logic [1:0] stateS;
    logic goS, scrS;

    sc_road_scroller #(
        .ROWS(8), .COLS(8), .TICK_DIV(64), .TICK_MIN(40),
        .GAP_ROWS(70), .SCORE_W(8), .SEED(16'hACE1)
    ) dutS (
        .SC_ROADSCROLLER_CLOCK_50(clk),
        .SC_ROADSCROLLER_RESET_InLow(rstN),
        .SC_ROADSCROLLER_startButton_InLow(stS),
        .SC_ROADSCROLLER_leftButton_InLow(lfS),
        .SC_ROADSCROLLER_rightButton_InLow(rtS),
        .SC_ROADSCROLLER_rowaddr_In(addrS),
        .SC_ROADSCROLLER_rowdata_OutBUS(rowS),
        .SC_ROADSCROLLER_score_OutBUS(scoreS),
        .SC_ROADSCROLLER_state_Out(stateS),
        .SC_ROADSCROLLER_gameover_OutLow(goS),
        .SC_ROADSCROLLER_scroll_Out(scrS)
    );
`endif

    task automatic drive(input int unit, input logic s, input logic l,
                         input logic r);
        case (unit)
            0: begin stA = s; lfA = l; rtA = r; end
            1: begin stB = s; lfB = l; rtB = r; end
`ifdef SC_ROADSCROLLER_SPEEDUP_EN
            2: begin stS = s; lfS = l; rtS = r; end
`endif
            default: ;
        endcase
    endtask

    // Hold pressed for one clock; result is visible on return
    task automatic press(input int unit, input logic s, input logic l,
                         input logic r);
        @(negedge clk);
        drive(unit, ~s, ~l, ~r);
        @(negedge clk);
        drive(unit, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
    endtask

    task automatic parkCar(input int unit, input int lane);
        int pos;
        pos = 4;
        while (pos > lane) begin press(unit, 0, 0, 1); pos--; end
        while (pos < lane) begin press(unit, 0, 1, 0); pos++; end
    endtask

    int pulses;
    int firstPulse;
    int lane;
    int cyc;
    int minGap;
    int pulseAt [0:80];
    logic [7:0] expCar [0:4];
    logic [7:0] laneMask;

    initial begin
        expCar[0] = 8'h08; expCar[1] = 8'h04; expCar[2] = 8'h02;
        expCar[3] = 8'h01; expCar[4] = 8'h01;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        // Reset state
        checkVal("rstState", stateA, 0);
        checkVal("rstScore", scoreA, 0);
        checkVal("rstGameover", goA, 1);
        checkVal("rstScroll", scrA, 0);
        checkVal("rstStateB", stateB, 0);
        addrA = 3'd7; #1;
        checkVal("rstRow7", rowA, 8'h10);
        for (int r = 0; r < 7; r++) begin
            addrA = 3'(r); #1;
            checkVal("rstRowEmpty", rowA, 0);
        end
        addrA = 3'd7;

        // Start with two-cycle latency, then scroll every 4 clocks
        @(negedge clk);
        stA = 1'b0;
        @(negedge clk);
        stA = 1'b1;
        checkVal("startLatency", stateA, 0);
        @(negedge clk);
        checkVal("startRun", stateA, 1);
        pulses = 0;
        firstPulse = -1;
        for (int j = 0; j < 40; j++) begin
            if (scrA) begin
                pulses++;
                if (firstPulse < 0) firstPulse = j;
            end
            @(negedge clk);
        end
        checkVal("scrollCount", pulses, 10);
        checkVal("scrollFirst", firstPulse, 3);
        @(negedge clk);
        checkVal("score40", scoreA, 10);

        // Car movement and saturation at the right edge
        for (int k = 0; k < 5; k++) begin
            press(0, 0, 0, 1);
            checkVal("carRight", rowA, expCar[k]);
        end
        press(0, 0, 1, 1);
        checkVal("carBoth", rowA, 8'h01);
        press(0, 0, 1, 0);
        checkVal("carLeft", rowA, 8'h02);
        press(0, 1, 0, 0);
        checkVal("startInRun", stateA, 1);

        // 4-bit score saturates rather than wrapping
        repeat (100) @(negedge clk);
        checkVal("scoreSat", scoreA, 15);

        // First obstacle lands after two LFSR steps; park in its lane
        lane = laneAfter(2);
        laneMask = 8'b1 << lane;
        press(1, 1, 0, 0);
        checkVal("bRun", stateB, 1);
        parkCar(1, lane);
        addrB = 3'd7; #1;
        checkVal("bCarParked", rowB, laneMask);
        for (int k = 0; k < 400 && scoreB != 8'd9; k++) @(negedge clk);
        checkVal("bScore9", scoreB, 9);
        addrB = 3'd6; #1;
        checkVal("bObstacleRow6", rowB, laneMask);
        addrB = 3'd7;
        for (int k = 0; k < 40 && scoreB != 8'd10; k++) @(negedge clk);
        #1;
        checkVal("bRow7Hit", rowB, laneMask);
        checkVal("bStillRun", stateB, 1);
        @(negedge clk);
        checkVal("bOver", stateB, 2);
        checkVal("bGameover", goB, 0);
        repeat (10) @(negedge clk);
        checkVal("bScoreFrozen", scoreB, 10);
        checkVal("bOverHeld", stateB, 2);
        press(1, 1, 0, 0);
        checkVal("bIdle", stateB, 0);
        checkVal("bGameoverClr", goB, 1);

`ifdef SC_ROADSCROLLER_SPEEDUP_EN
        // Period 64 -> 56 -> 49 -> 43 -> 40 floor
        lane = laneAfter(69);
        press(2, 1, 0, 0);
        checkVal("sRun", stateS, 1);
        parkCar(2, lane);
        for (int k = 0; k <= 80; k++) pulseAt[k] = 0;
        pulses = 0;
        cyc = 0;
        while (pulses < 77 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (scrS) begin
                pulses++;
                pulseAt[pulses] = cyc;
            end
        end
        checkVal("sPulses", pulses, 77);
        checkVal("sGap1", pulseAt[2] - pulseAt[1], 64);
        checkVal("sGap16", pulseAt[17] - pulseAt[16], 56);
        checkVal("sGap32", pulseAt[33] - pulseAt[32], 49);
        checkVal("sGap48", pulseAt[49] - pulseAt[48], 43);
        checkVal("sGap64", pulseAt[65] - pulseAt[64], 40);
        minGap = 1000;
        for (int k = 1; k < 77; k++) begin
            if (pulseAt[k+1] - pulseAt[k] < minGap) begin
                minGap = pulseAt[k+1] - pulseAt[k];
            end
        end
        checkVal("sMinGap", minGap, 40);
        repeat (2) @(negedge clk);
        checkVal("sOver", stateS, 2);
        checkVal("sScore", scoreS, 77);
        press(2, 1, 0, 0);
        checkVal("sIdle", stateS, 0);
        press(2, 1, 0, 0);
        checkVal("sRestart", stateS, 1);
        pulses = 0;
        cyc = 0;
        while (pulses < 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (scrS) begin
                pulses++;
                pulseAt[pulses] = cyc;
            end
        end
        checkVal("sRestartFirst", pulseAt[1], 64);
        checkVal("sRestartGap", pulseAt[2] - pulseAt[1], 64);
`endif

        // Asynchronous reset between clock edges
        checkVal("aRunBeforeRst", stateA, 1);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkVal("asyncState", stateA, 0);
        checkVal("asyncScore", scoreA, 0);
        checkVal("asyncGameover", goA, 1);
        checkVal("asyncScroll", scrA, 0);
        checkVal("asyncRow7", rowA, 8'h10);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
